// File: rtl/block_dispatch_pkg.sv
// Shared definitions for the kernel block dispatcher: FSM states, widths and
// the block-count helper used at launch.
package block_dispatch_pkg;

  localparam int TC_W  = 8;   // kernel thread count width
  localparam int BID_W = 8;   // block index / counter width
  localparam int TB_W  = 9;   // total_blocks width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } disp_state_e;

  // ceil(tc / 2**tpb_log), kept in 9 bits so no width is lost on the rounding add
  function automatic logic [TB_W-1:0] blocks_for(input logic [TC_W-1:0] tc,
                                                 input int unsigned   tpb_log);
    logic [TB_W-1:0] sum;
    sum = TB_W'(tc) + TB_W'((1 << tpb_log) - 1);
    return sum >> tpb_log;
  endfunction

endpackage

// File: rtl/block_dispatch_if.sv
// Kernel launch handshake plus per-core control/status bundle between the
// dispatcher (master) and the kernel host / core array (slave).
interface block_dispatch_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
);
  localparam int CTW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                start;
  logic [7:0]                          thread_count;
  logic                                done;
  logic [NUM_CORES-1:0]                core_start;
  logic [NUM_CORES-1:0]                core_reset;
  logic [NUM_CORES-1:0][7:0]           core_block_id;
  logic [NUM_CORES-1:0][CTW-1:0]       core_thread_count;
  logic [NUM_CORES-1:0]                core_done;

  modport master (
    input  start, thread_count, core_done,
    output done, core_start, core_reset, core_block_id, core_thread_count
  );

  modport slave (
    output start, thread_count, core_done,
    input  done, core_start, core_reset, core_block_id, core_thread_count
  );
endinterface

// File: rtl/block_dispatch.sv
// Kernel block dispatcher: splits a launch into THREADS_PER_BLOCK-sized blocks,
// hands one block at a time to the lowest free core and retires core dones.
module block_dispatch
  import block_dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic           clk,
  input  logic           reset,
  block_dispatch_if.master bus
);

  localparam int TPB_LOG = $clog2(THREADS_PER_BLOCK);
  localparam int CTW     = TPB_LOG + 1;
  localparam int IDXW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  disp_state_e state_q, state_d;
  logic        done_q, done_d;

  logic [TB_W-1:0]  total_blocks_q;
  logic [TC_W-1:0]  tc_lat_q;
  logic [BID_W-1:0] blocks_disp_q;
  logic [BID_W-1:0] blocks_done_q;

  logic [NUM_CORES-1:0]            start_q, rst_q;
  logic [NUM_CORES-1:0][BID_W-1:0] id_q;
  logic [NUM_CORES-1:0][CTW-1:0]   tcnt_q;

  logic [NUM_CORES-1:0] retire, free_v, disp_v;
  logic [TB_W-1:0]      n_retire, done_sum;
  logic                 launch, complete, disp_en;
  logic [IDXW-1:0]      disp_idx;
  logic [15:0]          rem;
  logic [CTW-1:0]       disp_tc;

  function automatic logic [IDXW-1:0] lowest_free(input logic [NUM_CORES-1:0] f);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (f[i]) idx = IDXW'(i);
    return idx;
  endfunction

  always_comb begin
    retire   = start_q & bus.core_done & ~rst_q;
    free_v   = ~start_q & ~rst_q;
    n_retire = '0;
    for (int i = 0; i < NUM_CORES; i++)
      n_retire = n_retire + TB_W'(retire[i]);
    done_sum = TB_W'(blocks_done_q) + n_retire;
    launch   = (state_q == IDLE) && bus.start;
    complete = (state_q == RUN) && (done_sum == total_blocks_q);
    disp_en  = (state_q == RUN) && !complete &&
               (TB_W'(blocks_disp_q) < total_blocks_q) && (|free_v);
    disp_idx = lowest_free(free_v);
    disp_v   = '0;
    if (disp_en) disp_v[disp_idx] = 1'b1;
    // Threads left for this block; only the last block can fall short of a full one
    rem      = 16'(tc_lat_q) - (16'(blocks_disp_q) << TPB_LOG);
    disp_tc  = (rem >= 16'(THREADS_PER_BLOCK)) ? CTW'(THREADS_PER_BLOCK) : rem[CTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (complete) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // wait for start to drop so a held launch level cannot rerun the kernel
        if (!bus.start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_blocks_q <= '0;
      tc_lat_q       <= '0;
      blocks_disp_q  <= '0;
      blocks_done_q  <= '0;
    end else if (launch) begin
      total_blocks_q <= blocks_for(bus.thread_count, TPB_LOG);
      tc_lat_q       <= bus.thread_count;
      blocks_disp_q  <= '0;
      blocks_done_q  <= '0;
    end else if (state_q == RUN) begin
      if (disp_en) blocks_disp_q <= blocks_disp_q + 1'b1;
      blocks_done_q <= done_sum[BID_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic             start_r, rst_r;
    logic [BID_W-1:0] id_r;
    logic [CTW-1:0]   tcnt_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        start_r <= 1'b0;
        rst_r   <= 1'b1;
        id_r    <= '0;
        tcnt_r  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            start_r <= 1'b0;
            rst_r   <= ~bus.start;
          end
          RUN: begin
            if (complete) begin
              start_r <= 1'b0;
              rst_r   <= 1'b1;
            end else begin
              // a retiring core sees a single reset cycle before it is free again
              rst_r <= retire[g];
              if (retire[g]) begin
                start_r <= 1'b0;
              end else if (disp_v[g]) begin
                start_r <= 1'b1;
                id_r    <= blocks_disp_q;
                tcnt_r  <= disp_tc;
              end
            end
          end
          default: begin
            start_r <= 1'b0;
            rst_r   <= 1'b1;
          end
        endcase
      end
    end

    assign start_q[g] = start_r;
    assign rst_q[g]   = rst_r;
    assign id_q[g]    = id_r;
    assign tcnt_q[g]  = tcnt_r;
  end

  assign bus.done              = done_q;
  assign bus.core_start        = start_q;
  assign bus.core_reset        = rst_q;
  assign bus.core_block_id     = id_q;
  assign bus.core_thread_count = tcnt_q;

endmodule

// File: tb/tb_block_dispatch.sv
// Directed bench for block_dispatch with a simple core model that raises
// core_done a fixed number of cycles after core_start.
module tb_block_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_dispatch_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) bus ();

  block_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic          auto_en;
  logic [NC-1:0] man_done;
  logic [NC-1:0] auto_done;
  int            dly;
  int            cnt [NC];

  assign bus.core_done = auto_en ? auto_done : man_done;

  // core model: done dly cycles after start is first seen, cleared by core_reset
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (bus.core_reset[c]) begin
        cnt[c]       <= 0;
        auto_done[c] <= 1'b0;
      end else if (bus.core_start[c] && !auto_done[c]) begin
        if (cnt[c] == dly - 1) auto_done[c] <= 1'b1;
        cnt[c] <= cnt[c] + 1;
      end
    end
  end

  int            lg_core [$];
  int            lg_id   [$];
  int            lg_tc   [$];
  logic [NC-1:0] prev_cs = '0;

  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (bus.core_start[c] && !prev_cs[c]) begin
        lg_core.push_back(c);
        lg_id.push_back(int'(bus.core_block_id[c]));
        lg_tc.push_back(int'(bus.core_thread_count[c]));
      end
    end
    prev_cs <= bus.core_start;
  end

  task automatic launch(input int tc);
    @(negedge clk);
    bus.thread_count = 8'(tc);
    bus.start        = 1'b1;
  endtask

  // cycles from the launch edge until done is seen; -1 if the budget expires
  task automatic wait_done(input int budget, output int cyc);
    int n;
    n   = 0;
    cyc = -1;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic end_kernel();
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.core_start !== 2'b00) begin failures++; $display("FAIL reset_core_start got %b want 00", bus.core_start); end
    checks++; if (bus.core_reset !== 2'b11) begin failures++; $display("FAIL reset_core_reset got %b want 11", bus.core_reset); end
    checks++; if (bus.core_block_id !== 16'h0) begin failures++; $display("FAIL reset_block_id got %h want 0", bus.core_block_id); end
    checks++; if (bus.core_thread_count !== 6'h0) begin failures++; $display("FAIL reset_thread_count got %h want 0", bus.core_thread_count); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.core_reset !== 2'b11) begin failures++; $display("FAIL idle_core_reset got %b want 11", bus.core_reset); end
  endtask

  task automatic check_blocks(input string nm, input int base, input int n,
                              input int ecore [3], input int eid [3], input int etc [3]);
    checks++;
    if (lg_core.size() - base != n) begin
      failures++; $display("FAIL %s_count got %0d want %0d", nm, lg_core.size() - base, n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (base + k >= lg_core.size()) begin
        failures++; $display("FAIL %s_blk%0d missing want core %0d id %0d tc %0d", nm, k, ecore[k], eid[k], etc[k]);
      end else if (lg_core[base+k] != ecore[k] || lg_id[base+k] != eid[k] || lg_tc[base+k] != etc[k]) begin
        failures++;
        $display("FAIL %s_blk%0d got core %0d id %0d tc %0d want core %0d id %0d tc %0d", nm, k,
                 lg_core[base+k], lg_id[base+k], lg_tc[base+k], ecore[k], eid[k], etc[k]);
      end
    end
  endtask

  task automatic test_basic();
    int base, cyc;
    auto_en = 1'b1; dly = 5;
    base = lg_core.size();
    launch(10);
    wait_done(100, cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL basic_done_cycle got %0d want 16", cyc); end
    checks++; if (bus.core_reset !== 2'b11) begin failures++; $display("FAIL basic_done_core_reset got %b want 11", bus.core_reset); end
    check_blocks("basic", base, 3, '{0, 1, 0}, '{0, 1, 2}, '{4, 4, 2});
    end_kernel();
  endtask

  task automatic test_zero();
    int base, cyc;
    base = lg_core.size();
    launch(0);
    wait_done(20, cyc);
    checks++; if (cyc != 2) begin failures++; $display("FAIL zero_done_cycle got %0d want 2", cyc); end
    checks++; if (lg_core.size() != base) begin failures++; $display("FAIL zero_no_dispatch got %0d want 0", lg_core.size() - base); end
    end_kernel();
  endtask

  task automatic test_simul_retire();
    auto_en = 1'b0; man_done = '0;
    launch(12);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.core_start !== 2'b11) begin failures++; $display("FAIL simul_busy got %b want 11", bus.core_start); end
    @(negedge clk); man_done = 2'b11;
    @(posedge clk); #1;
    checks++; if (bus.core_reset !== 2'b11 || bus.core_start !== 2'b00) begin failures++; $display("FAIL simul_pulse got reset %b start %b want 11 00", bus.core_reset, bus.core_start); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL simul_no_early_done got %b want 0", bus.done); end
    @(negedge clk); man_done = 2'b00;
    @(posedge clk); #1;
    checks++; if (bus.core_reset !== 2'b00 || bus.done !== 1'b0) begin failures++; $display("FAIL simul_pulse_end got reset %b done %b want 00 0", bus.core_reset, bus.done); end
    @(posedge clk); #1;
    checks++; if (bus.core_start !== 2'b01 || bus.core_block_id[0] !== 8'd2 || bus.core_thread_count[0] !== 3'd4) begin
      failures++; $display("FAIL simul_redispatch got start %b id %0d tc %0d want 01 2 4", bus.core_start, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    @(negedge clk); man_done = 2'b01;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL simul_done got %b want 1", bus.done); end
    @(negedge clk); man_done = 2'b00;
    end_kernel();
    auto_en = 1'b1;
  endtask

  task automatic test_big();
    int base, cyc, n, bad;
    dly = 2;
    base = lg_core.size();
    launch(255);
    wait_done(3000, cyc);
    checks++; if (cyc < 0) begin failures++; $display("FAIL big_done timeout got %0d want done", cyc); end
    n = lg_core.size() - base;
    checks++; if (n != 64) begin failures++; $display("FAIL big_count got %0d want 64", n); end
    checks++;
    if (n < 1 || lg_id[lg_id.size()-1] != 63 || lg_tc[lg_tc.size()-1] != 3) begin
      failures++; $display("FAIL big_last got n %0d id %0d tc %0d want 63 3", n,
                           (n > 0) ? lg_id[lg_id.size()-1] : -1, (n > 0) ? lg_tc[lg_tc.size()-1] : -1);
    end
    bad = 0;
    for (int k = 0; k < n - 1; k++)
      if (lg_id[base+k] != k || lg_tc[base+k] != 4) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL big_full_blocks got %0d bad want 0", bad); end
    end_kernel();
  endtask

  task automatic test_reset_mid();
    int base, cyc;
    dly = 20;
    launch(40);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.core_start !== 2'b11) begin failures++; $display("FAIL mid_busy got %b want 11", bus.core_start); end
    @(negedge clk); reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.core_start !== 2'b00 || bus.core_reset !== 2'b11 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mid_reset got start %b reset %b done %b want 00 11 0", bus.core_start, bus.core_reset, bus.done);
    end
    checks++; if (bus.core_block_id !== 16'h0) begin failures++; $display("FAIL mid_reset_id got %h want 0", bus.core_block_id); end
    @(negedge clk); reset = 1'b0;
    dly = 5;
    base = lg_core.size();
    launch(10);
    wait_done(100, cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL relaunch_done_cycle got %0d want 16", cyc); end
    check_blocks("relaunch", base, 3, '{0, 1, 0}, '{0, 1, 2}, '{4, 4, 2});
    end_kernel();
  endtask

  task automatic test_hold_start();
    int base, cyc;
    dly = 5;
    base = lg_core.size();
    launch(4);
    wait_done(100, cyc);
    checks++; if (cyc != 8) begin failures++; $display("FAIL hold_done_cycle got %0d want 8", cyc); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b1 || bus.core_reset !== 2'b11) begin failures++; $display("FAIL hold_stay_done got done %b reset %b want 1 11", bus.done, bus.core_reset); end
    checks++; if (lg_core.size() - base != 1) begin failures++; $display("FAIL hold_no_relaunch got %0d want 1", lg_core.size() - base); end
    end_kernel();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL hold_back_idle got %b want 0", bus.done); end
    base = lg_core.size();
    launch(6);
    wait_done(100, cyc);
    checks++; if (cyc != 9) begin failures++; $display("FAIL second_done_cycle got %0d want 9", cyc); end
    check_blocks("second", base, 2, '{0, 1, 0}, '{0, 1, 0}, '{4, 2, 0});
    end_kernel();
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.thread_count = '0;
    auto_en          = 1'b1;
    man_done         = '0;
    dly              = 5;
    test_reset();
    test_basic();
    test_zero();
    test_simul_retire();
    test_big();
    test_reset_mid();
    test_hold_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_dispatch.md
# block_dispatch

Kernel-level block dispatcher that sits directly upstream of the compute cores. It splits the launched thread count into blocks of `THREADS_PER_BLOCK` and hands one block at a time to each free core by driving that core's `start`, `block_id` and `thread_count` and its core-level reset. It collects each core's `done` and raises kernel `done` once every block has retired.

## Interface
Parameters:
- `NUM_CORES`, 2: number of cores served.
- `THREADS_PER_BLOCK`, 4: threads per block; must be a power of two, ≤ 128.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  kernel launch request, level.
- `thread_count`  in  8  total threads in the kernel; sampled on launch.
- `done`  out  1  kernel complete.
- `core_start`  out  NUM_CORES  per-core start, level; held while that core runs a block.
- `core_reset`  out  NUM_CORES  per-core synchronous reset.
- `core_block_id`  out  8 × NUM_CORES  block index for each core.
- `core_thread_count`  out  ($clog2(THREADS_PER_BLOCK)+1) × NUM_CORES  active threads in each core's block.
- `core_done`  in  NUM_CORES  per-core done, level; stays high until that core is reset.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `core_reset` = all ones, `core_start` = 0, `done` = 0.
  - When `start` = 1, the block latches `total_blocks = ceil(thread_count / THREADS_PER_BLOCK)`, clears `blocks_dispatched` and `blocks_done`, drives `core_reset` to 0 and moves to RUN.
- RUN, evaluated every cycle:
  - **Retire.** A core retires when `core_start[i]` & `core_done[i]` & !`core_reset[i]`. For each retiring core, the next cycle has `core_reset[i]` = 1 for exactly one cycle and `core_start[i]` = 0. `blocks_done` increases by the number of cores retiring in that cycle; simultaneous retirements are all counted.
  - **Dispatch.** A core is free when `core_start[i]` = 0 and `core_reset[i]` = 0. If `blocks_dispatched < total_blocks`, the lowest-index free core gets the next block:
    - `core_start[i]` <= 1.
    - `core_block_id[i]` <= `blocks_dispatched`.
    - `core_thread_count[i]` <= min(THREADS_PER_BLOCK, `thread_count_latched` − `blocks_dispatched`·THREADS_PER_BLOCK).
    - `blocks_dispatched` increments.
  - At most one dispatch happens per cycle.
  - A core that retires in cycle t becomes free at t+2 and can be re-dispatched at t+2, so its new `core_start` is visible at t+3.
  - **Completion.** When `blocks_done` (including this cycle's retirements) equals `total_blocks`, the block sets `done` <= 1 and `core_reset` <= all ones and moves to DONE.
- DONE: `done` = 1. When `start` = 0, the block returns to IDLE (`done` <= 0). Holding `start` high never relaunches the kernel.
- `core_block_id` and `core_thread_count` hold their values until the next dispatch to that core.
- Arithmetic:
  - Compute `total_blocks` in 9 bits; for `thread_count` = 255 and TPB = 4, `total_blocks` = 64.
  - The last block gets the remainder, which is never 0.
  - `blocks_dispatched`, `blocks_done` and `core_block_id` are 8 bits.
- Boundaries:
  - `thread_count` = 0 gives `total_blocks` = 0. The block goes RUN→DONE on the first RUN cycle with no dispatch.
  - A `core_done` from a core with `core_start` = 0 is ignored.
  - `reset` at any time returns IDLE values on the next edge. In-flight blocks are discarded.

## Timing
- Reset values:
  - state IDLE, `done` = 0.
  - `core_start` = 0, `core_reset` = all ones.
  - `core_block_id` = 0, `core_thread_count` = 0.
  - counters = 0.
- All outputs are registered; there are no combinational input→output paths.
- Launch sequence:
  - `start` sampled at edge 0.
  - RUN with `core_reset` = 0 at cycle 1.
  - First `core_start` high at cycle 2, second core at cycle 3, and so on.
- Completion: `done` rises one cycle after the edge at which the final `core_done` is sampled.

## Structure
- Put the state enum (IDLE, RUN, DONE) in the shared GPU package.
- Dispatch and retire live in a single module using a generate loop over cores for per-core registers.
- Put the lowest-free-index selection in a small combinational function inside the module.
- No sub-module is needed.

## Test plan
- NUM_CORES = 2, TPB = 4, `thread_count` = 10, each core's `core_done` asserted 5 cycles after its `core_start`:
  - block ids 0,1,2 go to cores 0,1,0.
  - `thread_count`s are 4,4,2.
  - `done` rises once after the third retirement.
- `thread_count` = 0, `start` = 1: no `core_start` ever rises; `done` = 1 at cycle 2.
- Both cores assert `core_done` in the same cycle: `blocks_done` += 2, each `core_reset` pulses exactly one cycle, and no double count occurs.
- `thread_count` = 255, TPB = 4: 64 blocks dispatched; last block id 63 has `thread_count` 3.
- `reset` asserted mid-RUN with both cores busy: next cycle IDLE, `core_start` = 0, `core_reset` = all ones, `done` = 0. A relaunch then completes normally.
- `start` held high after `done`: no relaunch. Drop `start`: back to IDLE. Raise it again: a second kernel runs with fresh block ids starting at 0.
